// File: rtl/sram_fifo_pkg.sv
// Shared defaults and helpers for the SRAM-backed FIFO controller.
package sram_fifo_pkg;

  localparam int DATA_WIDTH_DEF = 32;
  localparam int ADDR_WIDTH_DEF = 7;
  localparam int RAM_DEPTH_DEF  = 1 << ADDR_WIDTH_DEF;

  // Read/write pointer at default geometry: SRAM address plus one wrap bit.
  typedef logic [ADDR_WIDTH_DEF:0] ptr_t;

  // Output-pipeline slots that stay occupied after this cycle's pop:
  // words already buffered plus a read in flight, minus the word leaving.
  function automatic logic [2:0] slots_used(input logic [1:0] ob_cnt,
                                            input logic       inflight,
                                            input logic       pop);
    return {1'b0, ob_cnt} + {2'b00, inflight} - {2'b00, pop};
  endfunction

endpackage

// File: rtl/sram_fifo_outbuf.sv
// Two-entry output buffer holding words already read out of the SRAM.
// Entry 0 is always the head and drives pop_data directly from a flop.
module sram_fifo_outbuf
  import sram_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clear,
  input  logic                  load,
  input  logic [DATA_WIDTH-1:0] load_data,
  input  logic                  pop,
  output logic [DATA_WIDTH-1:0] data,
  output logic                  valid,
  output logic [1:0]            cnt
);

  logic [DATA_WIDTH-1:0] e0_q, e0_d;
  logic [DATA_WIDTH-1:0] e1_q, e1_d;
  logic [1:0]            cnt_q, cnt_d;

  // Next-state for the two entries: load appends, pop shifts entry 1 forward.
  always_comb begin
    e0_d  = e0_q;
    e1_d  = e1_q;
    cnt_d = cnt_q;
    if (clear) begin
      e0_d  = {DATA_WIDTH{1'b0}};
      e1_d  = {DATA_WIDTH{1'b0}};
      cnt_d = 2'd0;
    end else begin
      case ({load, pop})
        2'b10: begin
          if (cnt_q == 2'd0) begin
            e0_d  = load_data;
            cnt_d = 2'd1;
          end else if (cnt_q == 2'd1) begin
            e1_d  = load_data;
            cnt_d = 2'd2;
          end else begin
            cnt_d = cnt_q;
          end
        end
        2'b01: begin
          if (cnt_q == 2'd2) begin
            e0_d  = e1_q;
            cnt_d = 2'd1;
          end else if (cnt_q == 2'd1) begin
            cnt_d = 2'd0;
          end else begin
            cnt_d = cnt_q;
          end
        end
        2'b11: begin
          if (cnt_q == 2'd2) begin
            e0_d = e1_q;
            e1_d = load_data;
          end else begin
            e0_d  = load_data;
            cnt_d = 2'd1;
          end
        end
        default: begin
          cnt_d = cnt_q;
        end
      endcase
    end
  end

  // Entry and occupancy registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      e0_q  <= {DATA_WIDTH{1'b0}};
      e1_q  <= {DATA_WIDTH{1'b0}};
      cnt_q <= 2'd0;
    end else begin
      e0_q  <= e0_d;
      e1_q  <= e1_d;
      cnt_q <= cnt_d;
    end
  end

  assign data  = e0_q;
  assign valid = (cnt_q != 2'd0);
  assign cnt   = cnt_q;

endmodule

// File: rtl/sram_fifo_ctrl.sv
// FIFO controller over an external 1W1R SRAM with a two-entry output buffer.
// count tracks every word held (SRAM plus buffer plus in-flight read), so the
// total capacity is exactly RAM_DEPTH.
module sram_fifo_ctrl
  import sram_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int RAM_DEPTH  = 1 << ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  input  logic                  push_valid,
  output logic                  push_ready,
  input  logic [DATA_WIDTH-1:0] push_data,
  output logic                  pop_valid,
  input  logic                  pop_ready,
  output logic [DATA_WIDTH-1:0] pop_data,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  full,
  output logic                  empty,
  output logic                  mem_csb0,
  output logic [ADDR_WIDTH-1:0] mem_addr0,
  output logic [DATA_WIDTH-1:0] mem_din0,
  output logic                  mem_csb1,
  output logic [ADDR_WIDTH-1:0] mem_addr1,
  input  logic [DATA_WIDTH-1:0] mem_dout1
);

  localparam logic [ADDR_WIDTH:0] DEPTH_CNT = (ADDR_WIDTH + 1)'(RAM_DEPTH);
  localparam logic [ADDR_WIDTH:0] ONE       = (ADDR_WIDTH + 1)'(1);
  localparam logic [ADDR_WIDTH:0] ZERO      = (ADDR_WIDTH + 1)'(0);

  logic [ADDR_WIDTH:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_WIDTH:0] count_q, count_d;
  logic                inflight_q, inflight_d;

  logic [ADDR_WIDTH:0] sram_occ;
  logic                push_acc;
  logic                pop_acc;
  logic                rd_issue;
  logic [1:0]          ob_cnt;
  logic                ob_valid;
  logic [DATA_WIDTH-1:0] ob_data;

  assign full       = (count_q == DEPTH_CNT);
  assign empty      = (count_q == ZERO);
  assign count      = count_q;
  // rst_n gating keeps push_ready low while the block is held in reset.
  assign push_ready = rst_n && !full && !flush;
  assign push_acc   = push_valid && push_ready;
  assign pop_valid  = ob_valid;
  assign pop_data   = ob_data;
  assign pop_acc    = ob_valid && pop_ready;

  // The wrap bit lets occupancy distinguish a full SRAM from an empty one.
  assign sram_occ = wr_ptr_q - rd_ptr_q;
  // Prefetch only while a buffer slot will be free to catch the returning word.
  assign rd_issue = rst_n && !flush && (sram_occ != ZERO) &&
                    (slots_used(ob_cnt, inflight_q, pop_acc) < 3'd2);

  assign mem_csb0  = !push_acc;
  assign mem_addr0 = wr_ptr_q[ADDR_WIDTH-1:0];
  assign mem_din0  = push_data;
  assign mem_csb1  = !rd_issue;
  assign mem_addr1 = rd_ptr_q[ADDR_WIDTH-1:0];

  // Pointer, count and in-flight next-state; flush clears everything.
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    inflight_d = inflight_q;
    if (flush) begin
      wr_ptr_d   = ZERO;
      rd_ptr_d   = ZERO;
      count_d    = ZERO;
      inflight_d = 1'b0;
    end else begin
      if (push_acc) begin
        wr_ptr_d = wr_ptr_q + ONE;
      end else begin
        wr_ptr_d = wr_ptr_q;
      end
      if (rd_issue) begin
        rd_ptr_d = rd_ptr_q + ONE;
      end else begin
        rd_ptr_d = rd_ptr_q;
      end
      case ({push_acc, pop_acc})
        2'b10:   count_d = count_q + ONE;
        2'b01:   count_d = count_q - ONE;
        default: count_d = count_q;
      endcase
      inflight_d = rd_issue;
    end
  end

  // Controller state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q   <= ZERO;
      rd_ptr_q   <= ZERO;
      count_q    <= ZERO;
      inflight_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      inflight_q <= inflight_d;
    end
  end

  // Read data returning during a flush belongs to discarded contents.
  sram_fifo_outbuf #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_outbuf (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (flush),
    .load      (inflight_q && !flush),
    .load_data (mem_dout1),
    .pop       (pop_acc && !flush),
    .data      (ob_data),
    .valid     (ob_valid),
    .cnt       (ob_cnt)
  );

endmodule

// File: tb/tb_sram_fifo_ctrl.sv
// Randomized bench for sram_fifo_ctrl with an SRAM model and a queue-based
// reference: a word pushed at edge T is at the head no earlier than edge T+2.
module tb_sram_fifo_ctrl;

  localparam int DW    = 32;
  localparam int AW    = 7;
  localparam int DEPTH = 128;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          flush = 1'b0;
  logic          push_valid = 1'b0;
  logic          push_ready;
  logic [DW-1:0] push_data = 32'h0;
  logic          pop_valid;
  logic          pop_ready = 1'b0;
  logic [DW-1:0] pop_data;
  logic [AW:0]   count;
  logic          full;
  logic          empty;
  logic          mem_csb0;
  logic [AW-1:0] mem_addr0;
  logic [DW-1:0] mem_din0;
  logic          mem_csb1;
  logic [AW-1:0] mem_addr1;
  logic [DW-1:0] mem_dout1 = 32'h0;

  int     total = 0;
  int     bad   = 0;
  longint edge_n = 0;

  typedef struct {
    logic [31:0] d;
    longint      t;
  } ent_t;
  ent_t q[$];

  logic [DW-1:0] sram [DEPTH];

  sram_fifo_ctrl dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .flush      (flush),
    .push_valid (push_valid),
    .push_ready (push_ready),
    .push_data  (push_data),
    .pop_valid  (pop_valid),
    .pop_ready  (pop_ready),
    .pop_data   (pop_data),
    .count      (count),
    .full       (full),
    .empty      (empty),
    .mem_csb0   (mem_csb0),
    .mem_addr0  (mem_addr0),
    .mem_din0   (mem_din0),
    .mem_csb1   (mem_csb1),
    .mem_addr1  (mem_addr1),
    .mem_dout1  (mem_dout1)
  );

  always #5 clk = ~clk;

  // SRAM model: read data one edge after the read; garbage when not reading.
  always @(posedge clk) begin
    if (!mem_csb0) sram[mem_addr0] <= mem_din0;
    if (!mem_csb1) mem_dout1 <= sram[mem_addr1];
    else           mem_dout1 <= $urandom;
  end

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (edge %0d)", tag, obs, exp, edge_n);
    end
  endtask

  // One clock cycle: drive, check against the model, clock, update the model.
  task automatic step(input logic pv, input logic [31:0] pd, input logic pr, input logic fl);
    logic e_valid, e_pready, acc_push, acc_pop;
    push_valid = pv;
    push_data  = pd;
    pop_ready  = pr;
    flush      = fl;
    #3;
    e_valid  = (q.size() > 0) && (q[0].t <= edge_n - 2);
    e_pready = (q.size() < DEPTH) && !fl;
    acc_push = pv && e_pready;
    acc_pop  = pr && e_valid;
    check_val("count", 64'(count), 64'(q.size()));
    check_val("full", 64'(full), 64'(q.size() == DEPTH));
    check_val("empty", 64'(empty), 64'(q.size() == 0));
    check_val("push_ready", 64'(push_ready), 64'(e_pready));
    check_val("pop_valid", 64'(pop_valid), 64'(e_valid));
    if (e_valid) check_val("pop_data", 64'(pop_data), 64'(q[0].d));
    check_val("csb0", 64'(mem_csb0), 64'(!acc_push));
    check_val("addr_collide", 64'(!mem_csb0 && !mem_csb1 && (mem_addr0 == mem_addr1)), 64'(0));
    if (fl) check_val("csb1_flush", 64'(mem_csb1), 64'(1));
    @(posedge clk);
    edge_n++;
    if (fl) begin
      q.delete();
    end else begin
      if (acc_pop) void'(q.pop_front());
      if (acc_push) q.push_back('{pd, edge_n});
    end
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check_val({tag, "_pop_valid"}, 64'(pop_valid), 64'(0));
    check_val({tag, "_empty"}, 64'(empty), 64'(1));
    check_val({tag, "_full"}, 64'(full), 64'(0));
    check_val({tag, "_push_ready"}, 64'(push_ready), 64'(0));
    check_val({tag, "_csb0"}, 64'(mem_csb0), 64'(1));
    check_val({tag, "_csb1"}, 64'(mem_csb1), 64'(1));
    check_val({tag, "_pop_data"}, 64'(pop_data), 64'(0));
    check_val({tag, "_count"}, 64'(count), 64'(0));
  endtask

  // Hold reset for ncyc edges while requests are active; release after an edge.
  task automatic do_reset(input int ncyc, input string tag);
    rst_n      = 1'b0;
    push_valid = 1'b1;
    push_data  = 32'hA5A5_A5A5;
    pop_ready  = 1'b1;
    flush      = 1'b0;
    q.delete();
    #2;
    check_reset_outputs(tag);
    repeat (ncyc) begin
      @(posedge clk);
      edge_n++;
    end
    #1;
    check_reset_outputs({tag, "_late"});
    rst_n = 1'b1;
  endtask

  task automatic drain(input string tag);
    int guard = 0;
    while (q.size() > 0 && guard < 400) begin
      step(1'b0, 32'h0, 1'b1, 1'b0);
      guard++;
    end
    step(1'b0, 32'h0, 1'b1, 1'b0);
    check_val({tag, "_drained"}, 64'(empty), 64'(1));
  endtask

  initial begin
    @(posedge clk);
    edge_n++;
    #1;
    do_reset(2, "rst0");

    // Single word through an empty FIFO.
    step(1'b1, 32'hDEAD_BEEF, 1'b0, 1'b0);
    step(1'b0, 32'h0, 1'b0, 1'b0);
    step(1'b0, 32'h0, 1'b0, 1'b0);
    check_val("single_valid", 64'(pop_valid), 64'(1));
    check_val("single_data", 64'(pop_data), 64'h0000_0000_DEAD_BEEF);
    drain("single");

    // Fill to capacity, one extra push refused, then drain in order.
    for (int i = 0; i < DEPTH; i++) step(1'b1, 32'(i), 1'b0, 1'b0);
    check_val("fill_full", 64'(full), 64'(1));
    check_val("fill_count", 64'(count), 64'(DEPTH));
    step(1'b1, 32'h0000_0999, 1'b0, 1'b0);
    check_val("fill_still_full", 64'(count), 64'(DEPTH));
    drain("fill");

    // Streaming with continuous pops across two pointer wraps.
    for (int i = 0; i < 300; i++) step(1'b1, 32'h1000 + 32'(i), 1'b1, 1'b0);
    drain("stream");

    // Random traffic with occasional flushes and shifting pressure.
    for (int i = 0; i < 10000; i++) begin
      int pp, rp;
      pp = (i < 5000) ? 50 : 70;
      rp = (i < 5000) ? 70 : 35;
      step(1'($urandom_range(0, 99) < pp), $urandom, 1'($urandom_range(0, 99) < rp),
           1'($urandom_range(0, 999) == 0));
    end
    drain("random");

    // Flush while a read is in flight.
    for (int i = 0; i < 5; i++) step(1'b1, 32'h500 + 32'(i), 1'b0, 1'b0);
    repeat (4) step(1'b0, 32'h0, 1'b0, 1'b0);
    step(1'b0, 32'h0, 1'b1, 1'b0);
    step(1'b0, 32'h0, 1'b0, 1'b1);
    check_val("flush_count", 64'(count), 64'(0));
    check_val("flush_empty", 64'(empty), 64'(1));
    repeat (3) step(1'b0, 32'h0, 1'b1, 1'b0);
    check_val("flush_no_stale", 64'(pop_valid), 64'(0));

    // Reset mid-stream with ten words held.
    for (int i = 0; i < 10; i++) step(1'b1, 32'h700 + 32'(i), 1'b0, 1'b0);
    repeat (3) step(1'b0, 32'h0, 1'b0, 1'b0);
    do_reset(2, "rst_mid");
    step(1'b1, 32'h0000_0001, 1'b0, 1'b0);
    check_val("post_rst_count", 64'(count), 64'(1));
    step(1'b0, 32'h0, 1'b0, 1'b0);
    step(1'b0, 32'h0, 1'b0, 1'b0);
    check_val("post_rst_data", 64'(pop_data), 64'(1));
    drain("post_rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
